// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - NZCV flags register with grouped writes and one-entry save/restore copy
module flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             ALUCarry,
  input  logic             ALUOverflow,
  input  logic [1:0]       FlagW,
  input  logic             CondEx,
  input  logic             Stall,
  input  logic             SaveFlags,
  input  logic             RestoreFlags,
  output logic [3:0]       Flags,
  output logic [3:0]       SavedFlags,
  output logic             FlagsUpd
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] saved_q, saved_d;
  logic       upd_q, upd_d;
  logic       nn, zn;
  logic       we_nz, we_cv, restore_en, save_en;

  assign nn = ALUResult[WIDTH-1];
  assign zn = (ALUResult == '0);

  assign restore_en = RestoreFlags & ~Stall;
  assign save_en    = SaveFlags & ~Stall;
  assign we_nz      = FlagW[1] & CondEx & ~Stall & ~RestoreFlags;
  assign we_cv      = FlagW[0] & CondEx & ~Stall & ~RestoreFlags;

  // Save always reads the pre-edge flags, so save+restore swaps the two copies.
  always_comb begin
    flags_d = flags_q;
    saved_d = saved_q;
    upd_d   = upd_q;
    if (restore_en) begin
      flags_d = saved_q;
    end else begin
      if (we_nz) flags_d[3:2] = {nn, zn};
      if (we_cv) flags_d[1:0] = {ALUCarry, ALUOverflow};
    end
    if (save_en) saved_d = flags_q;
    if (!Stall)  upd_d   = we_nz | we_cv | restore_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
      saved_q <= 4'b0000;
      upd_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      saved_q <= saved_d;
      upd_q   <= upd_d;
    end
  end

  assign Flags      = flags_q;
  assign SavedFlags = saved_q;
  assign FlagsUpd   = upd_q;

endmodule
